// File: rtl/countdown_timer.sv
// countdown_timer
// Loadable down-counter/timer. A value is loaded into the reload register R
// and into Q. A start command arms the run. Q then decrements on every
// enabled cycle until the terminal event (Q==1 with en=1). That event raises
// a one-cycle done pulse. After it, the timer either stops at zero (one-shot)
// or reloads R and keeps running (periodic).
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load        capture load_val into R and Q, abort any run
//   load_val    value to load (WIDTH bits)
//   start       arm the countdown from IDLE (ignored when Q==0 or in RUN)
//   stop        abort a run, Q holds its value
//   en          count enable, effective only in RUN
//   reload_mode 1 = periodic auto-reload, 0 = one-shot
//   Q           current count (registered)
//   busy        high while in RUN (registered)
//   done        one-cycle terminal-count pulse (registered)
module countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             reload_mode,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_val;

    // Command priority: load > stop > start/count. The outputs are updated
    // together with the state, so busy always matches the state after each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            Q          <= '0;
            reload_val <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: this block uses only non-blocking assignments. Every register
            // then sees the values from before the edge, and the last assignment
            // wins. That is why the default below can be overridden later.
            done <= 1'b0;

            if (load) begin
                reload_val <= load_val;
                Q          <= load_val;
                state      <= IDLE;
                busy       <= 1'b0;
            end else if (stop) begin
                // In RUN, stop aborts the run and Q is held for a later resume.
                // In IDLE, stop simply outranks start.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A zero count cannot be armed: no run and no done.
                        if (start && (Q != '0)) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (en) begin
                            if (Q == ONE) begin
                                // Terminal event. Q is never 0 in RUN, so the
                                // count cannot underflow.
                                done <= 1'b1;
                                if (reload_mode) begin
                                    Q <= reload_val;
                                end else begin
                                    Q     <= '0;
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                Q <= Q - ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Directed scenarios for reset, one-shot, auto-reload, enable gaps with
// stop/resume, command priority and the full-width boundary. A randomized
// run is then checked against a behavioural model of the timer rules.
module tb_countdown_timer;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         en;
    logic         reload_mode;
    logic [W-1:0] Q;
    logic         busy;
    logic         done;

    int vectors;
    int miscompares;

    // Behavioural model state: count, reload value, running flag, done pulse.
    int unsigned m_q;
    int unsigned m_r;
    bit          m_run;
    bit          m_done;

    countdown_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .reload_mode (reload_mode),
        .Q           (Q),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and land 1 time unit after it, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load     = 1'b0;
        load_val = '0;
        start    = 1'b0;
        stop     = 1'b0;
        en       = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reload_mode = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_load(input logic [W-1:0] v);
        clear_inputs();
        load     = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic en_val);
        start = 1'b1;
        en    = en_val;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+1:0] exp;
        reset_dut();
        do_load(16'h0124);
        do_start(1'b1);
        tick();
        exp = {16'h0123, 1'b1, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL reset_precond: got {Q,busy,done}=%h expected %h", {Q, busy, done}, exp);
        end
        // Assert reset between edges and check that it acts at once.
        #2;
        rst_n = 1'b0;
        #1;
        exp = '0;
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL reset_async: got {Q,busy,done}=%h expected %h", {Q, busy, done}, exp);
        end
        #1;
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL reset_resume_idle: got {Q,busy,done}=%h expected %h", {Q, busy, done}, exp);
        end
    endtask

    task automatic test_one_shot();
        logic [W+1:0] exp;
        reset_dut();
        do_load(16'd5);
        do_start(1'b1);
        exp = {16'd5, 1'b1, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL one_shot_start: got %h expected %h", {Q, busy, done}, exp);
        end
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 5) exp = {W'(5 - k), (k < 5), (k == 5)};
            else        exp = {16'd0, 1'b0, 1'b0};
            vectors++;
            if ({Q, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL one_shot_edge%0d: got %h expected %h", k, {Q, busy, done}, exp);
            end
        end
        clear_inputs();
    endtask

    task automatic test_auto_reload();
        logic [W+1:0] exp;
        reset_dut();
        reload_mode = 1'b1;
        do_load(16'd3);
        do_start(1'b1);
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = {W'((k % 3 == 0) ? 3 : 3 - (k % 3)), 1'b1, (k % 3 == 0)};
            vectors++;
            if ({Q, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL auto_reload_edge%0d: got %h expected %h", k, {Q, busy, done}, exp);
            end
        end
        clear_inputs();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        reload_mode = 1'b0;
    endtask

    task automatic test_en_gaps_stop();
        logic [W+1:0] exp;
        logic [3:0]   pattern;
        reset_dut();
        do_load(16'd4);
        do_start(1'b0);
        pattern = 4'b1001;
        for (int k = 3; k >= 0; k--) begin
            en = pattern[k];
            tick();
        end
        exp = {16'd2, 1'b1, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL en_gaps: got %h expected %h", {Q, busy, done}, exp);
        end
        en   = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        exp = {16'd2, 1'b0, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL stop_hold: got %h expected %h", {Q, busy, done}, exp);
        end
        do_start(1'b1);
        en = 1'b1;
        tick();
        exp = {16'd1, 1'b1, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL resume_edge1: got %h expected %h", {Q, busy, done}, exp);
        end
        tick();
        exp = {16'd0, 1'b0, 1'b1};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL resume_done: got %h expected %h", {Q, busy, done}, exp);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        logic [W+1:0] exp;
        reset_dut();
        // load and start together: load wins.
        load     = 1'b1;
        load_val = 16'h0010;
        start    = 1'b1;
        en       = 1'b1;
        tick();
        clear_inputs();
        tick();
        exp = {16'h0010, 1'b0, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL load_beats_start: got %h expected %h", {Q, busy, done}, exp);
        end
        // start with Q==0 is ignored.
        do_load(16'd0);
        do_start(1'b1);
        en = 1'b1;
        tick();
        exp = '0;
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL start_at_zero: got %h expected %h", {Q, busy, done}, exp);
        end
        // load during RUN with Q==7.
        do_load(16'd9);
        do_start(1'b1);
        en = 1'b1;
        tick();
        tick();
        exp = {16'd7, 1'b1, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL run_to_7: got %h expected %h", {Q, busy, done}, exp);
        end
        load     = 1'b1;
        load_val = 16'h0020;
        tick();
        load = 1'b0;
        exp = {16'h0020, 1'b0, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL load_in_run: got %h expected %h", {Q, busy, done}, exp);
        end
        // load on what would be the terminal edge suppresses done.
        do_load(16'd1);
        do_start(1'b1);
        load     = 1'b1;
        load_val = 16'd6;
        en       = 1'b1;
        tick();
        exp = {16'd6, 1'b0, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL load_at_terminal: got %h expected %h", {Q, busy, done}, exp);
        end
        clear_inputs();
    endtask

    task automatic test_width_boundary();
        logic [W+1:0] exp;
        int           bad;
        reset_dut();
        do_load(16'hFFFF);
        do_start(1'b1);
        en = 1'b1;
        tick();
        exp = {16'hFFFE, 1'b1, 1'b0};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL width_first_dec: got %h expected %h", {Q, busy, done}, exp);
        end
        bad = 0;
        for (int k = 2; k <= 65534; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b1 || Q !== W'(65535 - k)) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL width_countdown: got %0d bad edges expected 0", bad);
        end
        tick();
        exp = {16'd0, 1'b0, 1'b1};
        vectors++;
        if ({Q, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL width_terminal: got %h expected %h", {Q, busy, done}, exp);
        end
        clear_inputs();
    endtask

    // Model of the timer rules, applied to the inputs present at the coming edge.
    task automatic model_step();
        m_done = 1'b0;
        if (load) begin
            m_r   = load_val;
            m_q   = load_val;
            m_run = 1'b0;
        end else if (stop) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (start && m_q != 0) m_run = 1'b1;
        end else if (en) begin
            if (m_q == 1) begin
                m_done = 1'b1;
                if (reload_mode) begin
                    m_q = m_r;
                end else begin
                    m_q   = 0;
                    m_run = 1'b0;
                end
            end else begin
                m_q = m_q - 1;
            end
        end
    endtask

    task automatic test_random();
        logic [W+1:0] exp;
        reset_dut();
        m_q = 0; m_r = 0; m_run = 1'b0; m_done = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            load        = ($urandom_range(0, 99) < 6);
            load_val    = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 1))
                                                      : W'($urandom_range(1, 9));
            stop        = ($urandom_range(0, 99) < 4);
            start       = ($urandom_range(0, 99) < 25);
            en          = ($urandom_range(0, 99) < 70);
            reload_mode = ($urandom_range(0, 99) < 40);
            model_step();
            tick();
            exp = {W'(m_q), m_run, m_done};
            vectors++;
            if ({Q, busy, done} !== exp) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, {Q, busy, done}, exp);
            end
        end
        clear_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        reload_mode = 1'b0;
        clear_inputs();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_en_gaps_stop();
        test_priority();
        test_width_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
